// File: rtl/muldiv_pkg.sv
// Shared types and op encodings for the iterative multiply/divide unit.
package muldiv_pkg;

  // Op field encodings as seen on the Op port.
  localparam logic [1:0] OPC_MUL   = 2'b00;
  localparam logic [1:0] OPC_DIV   = 2'b01;
  localparam logic [1:0] OPC_MULLO = 2'b10;
  localparam logic [1:0] OPC_REM   = 2'b11;

  typedef enum logic [1:0] {
    OP_MUL   = OPC_MUL,
    OP_DIV   = OPC_DIV,
    OP_MULLO = OPC_MULLO,
    OP_REM   = OPC_REM
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    WB_LO = 2'd2,
    WB_HI = 2'd3
  } state_t;

  // Multiply-class ops use the shift-add datapath.
  function automatic logic is_mul_op(input op_t op);
    return (op == OP_MUL) || (op == OP_MULLO);
  endfunction

  // Ops that produce a second write-back cycle.
  function automatic logic is_two_write(input op_t op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Iterative multiply/divide unit: latches operands on Start, runs W shift
// steps, then writes one or two results into the register file.
//
// Handshake: Start is a request that is only honoured while the unit is
// IDLE (Busy=0); a Start seen while Busy is dropped, nothing is queued.
// Each write-back cycle is a single-cycle WriteEn strobe with Waddr/DataOut
// valid in that same cycle; there is no ready/backpressure from the
// register file, and Done marks the last of those write cycles.
module iter_muldiv
  import muldiv_pkg::*;
#(
  parameter int W = 8,
  parameter int D = 3
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [1:0]   Op,
  input  logic [W-1:0] OperandA,
  input  logic [W-1:0] OperandB,
  input  logic [D-1:0] DestAddr,
  output logic         Busy,
  output logic         Done,
  output logic         WriteEn,
  output logic [D-1:0] Waddr,
  output logic [W-1:0] DataOut,
  output state_t       DbgState
);

  localparam int CW = $clog2(W);

  state_t         state_q, state_nx;
  op_t            op_q;
  logic [D-1:0]   dest_q;
  logic [CW-1:0]  cnt_q;
  // m_q holds the multiplicand (MUL) or divisor (DIV).
  // hi_q:lo_q is the product during MUL, remainder:quotient during DIV.
  logic [W-1:0]   m_q;
  logic [W-1:0]   hi_q;
  logic [W-1:0]   lo_q;

  logic [W:0]     mul_sum;
  logic [W:0]     div_trial;

  assign DbgState = state_q;

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE:    if (Start) state_nx = CALC;
      CALC:    if (cnt_q == '0) state_nx = WB_LO;
      WB_LO:   state_nx = is_two_write(op_q) ? WB_HI : IDLE;
      WB_HI:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // One step of each algorithm, computed from the current accumulators.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    // Shifted partial remainder minus divisor; bit W set means borrow.
    div_trial = {hi_q, lo_q[W-1]} - {1'b0, m_q};
  end

  // Operand latch, counter and shift/accumulate datapath.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      op_q   <= OP_MUL;
      dest_q <= '0;
      cnt_q  <= '0;
      m_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            op_q   <= op_t'(Op);
            dest_q <= DestAddr;
            cnt_q  <= CW'(W - 1);
            hi_q   <= '0;
            if (is_mul_op(op_t'(Op))) begin
              m_q  <= OperandA;
              lo_q <= OperandB;
            end else begin
              m_q  <= OperandB;
              lo_q <= OperandA;
            end
          end
        end
        CALC: begin
          cnt_q <= cnt_q - 1'b1;
          if (is_mul_op(op_q)) begin
            hi_q <= mul_sum[W:1];
            lo_q <= {mul_sum[0], lo_q[W-1:1]};
          end else if (!div_trial[W]) begin
            hi_q <= div_trial[W-1:0];
            lo_q <= {lo_q[W-2:0], 1'b1};
          end else begin
            // Restore: the shifted remainder is below the divisor, so it fits W bits.
            hi_q <= {hi_q[W-2:0], lo_q[W-1]};
            lo_q <= {lo_q[W-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode from registered state only.
  always_comb begin
    Busy    = (state_q != IDLE);
    WriteEn = 1'b0;
    Done    = 1'b0;
    Waddr   = '0;
    DataOut = '0;
    case (state_q)
      WB_LO: begin
        WriteEn = 1'b1;
        Done    = !is_two_write(op_q);
        Waddr   = dest_q;
        DataOut = (op_q == OP_REM) ? hi_q : lo_q;
      end
      WB_HI: begin
        WriteEn = 1'b1;
        Done    = 1'b1;
        Waddr   = dest_q + 1'b1;
        DataOut = hi_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_iter_muldiv.sv
// Directed bench for iter_muldiv: hand-computed results, per-cycle control
// checks and an expected write queue.
module tb_iter_muldiv;
  import muldiv_pkg::*;

  localparam int W = 8;
  localparam int D = 3;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         Start;
  logic [1:0]   Op;
  logic [W-1:0] OperandA;
  logic [W-1:0] OperandB;
  logic [D-1:0] DestAddr;
  logic         Busy;
  logic         Done;
  logic         WriteEn;
  logic [D-1:0] Waddr;
  logic [W-1:0] DataOut;
  state_t       DbgState;

  int n_tests = 0;
  int n_fail  = 0;
  logic [D+W-1:0] exp_q[$];

  iter_muldiv #(.W(W), .D(D)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .Op       (Op),
    .OperandA (OperandA),
    .OperandB (OperandB),
    .DestAddr (DestAddr),
    .Busy     (Busy),
    .Done     (Done),
    .WriteEn  (WriteEn),
    .Waddr    (Waddr),
    .DataOut  (DataOut),
    .DbgState (DbgState)
  );

  // Clock: 10 time-unit period.
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op at the next negedge (sampled at "edge 0"), then observe
  // cycles 1..10. rst_at!=0 asserts Reset in that cycle and expects no writes.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [D-1:0] dest, input logic [W-1:0] lo,
                        input logic [D-1:0] hi_addr, input logic [W-1:0] hi,
                        input int nwr, input bit disturb, input int rst_at, input string name);
    int last;
    logic [D+W-1:0] e;
    logic exp_wen;
    @(negedge Clk);
    Op       = op;
    OperandA = a;
    OperandB = b;
    DestAddr = dest;
    Start    = 1'b1;
    if (rst_at == 0) begin
      exp_q.push_back({dest, lo});
      if (nwr == 2) exp_q.push_back({hi_addr, hi});
    end
    last = (rst_at != 0) ? rst_at : 8 + nwr;
    @(posedge Clk);
    #1 Start = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge Clk);
      exp_wen = (rst_at == 0) && (cyc == 9 || (cyc == 10 && nwr == 2));
      check($sformatf("%s_ctl_c%0d", name, cyc), {Busy, WriteEn, Done},
            {(cyc <= last), exp_wen, (rst_at == 0 && cyc == last)});
      if (WriteEn) begin
        if (exp_q.size() == 0) check($sformatf("%s_wr_unexpected_c%0d", name, cyc), WriteEn, 1'b0);
        else begin
          e = exp_q.pop_front();
          check($sformatf("%s_wr_c%0d", name, cyc), {Waddr, DataOut}, e);
        end
      end
      if (rst_at != 0 && cyc == rst_at + 1) begin
        check($sformatf("%s_rst_state", name), DbgState, IDLE);
        check($sformatf("%s_rst_port", name), {Waddr, DataOut}, '0);
      end
      // Drive for the upcoming edge.
      Start = disturb && (cyc == 3 || cyc == 6);
      if (Start) begin
        Op       = 2'($urandom_range(0, 3));
        OperandA = 8'($urandom_range(0, 255));
        OperandB = 8'($urandom_range(0, 255));
        DestAddr = 3'($urandom_range(0, 7));
      end
      Reset = (rst_at != 0 && cyc == rst_at);
    end
    Reset = 1'b0;
    check($sformatf("%s_drain", name), exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    Reset    = 1'b1;
    Start    = 1'b0;
    Op       = 2'b00;
    OperandA = '0;
    OperandB = '0;
    DestAddr = '0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("reset_ctl", {Busy, WriteEn, Done}, 3'b000);
    check("reset_waddr", Waddr, 0);
    check("reset_data", DataOut, 0);
    check("reset_state", DbgState, IDLE);
    Reset = 1'b0;

    //     op         a    b    dest lo    hiaddr hi   nwr dist rst
    run_op(OPC_MUL,   13,  20,  2,   8'h04, 3,    8'h01, 2, 0, 0, "mul13x20");
    run_op(OPC_DIV,   200, 7,   4,   28,    5,    4,     2, 0, 0, "div200_7");
    run_op(OPC_DIV,   45,  0,   4,   255,   5,    45,    2, 0, 0, "div45_0");
    run_op(OPC_MULLO, 255, 255, 1,   8'h01, 0,    0,     1, 0, 0, "mullo255");
    run_op(OPC_REM,   200, 7,   1,   4,     0,    0,     1, 0, 0, "rem200_7");
    run_op(OPC_MUL,   16,  16,  7,   8'h00, 0,    8'h01, 2, 0, 0, "mul_wrap");
    run_op(OPC_MULLO, 12,  11,  5,   8'h84, 0,    0,     1, 0, 0, "mullo12x11");
    run_op(OPC_REM,   255, 16,  6,   15,    0,    0,     1, 0, 0, "rem255_16");
    // Start pulses mid-op with new operands; then a Start right after Done.
    run_op(OPC_MUL,   100, 3,   6,   8'h2C, 7,    8'h01, 2, 1, 0, "mul_disturb");
    run_op(OPC_DIV,   100, 9,   3,   11,    4,    1,     2, 0, 0, "div_b2b");
    // Reset in cycle 5 of a DIV, then a clean DIV.
    run_op(OPC_DIV,   50,  6,   0,   0,     0,    0,     2, 0, 5, "div_reset");
    run_op(OPC_DIV,   50,  6,   0,   8,     1,    2,     2, 0, 0, "div_after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
